// File: rtl/datapath_bus.sv
// Register/bus datapath for the processor controller: PC, AR, IR, AC, R, R1-R4, shared bus and ALU.
// Optional multiplier on alu_op=3 is built only when DATAPATH_MULT_EN is defined.
module datapath_bus #(
  parameter int DATA_W = 16,
  parameter int OPC_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        read_en,
  input  logic [15:0]       write_en,
  input  logic [15:0]       inc_en,
  input  logic [15:0]       clr_en,
  input  logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] im_rdata,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic [DATA_W-1:0] im_addr,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              dm_we,
  output logic [OPC_W-1:0]  instruction,
  output logic [15:0]       z,
  output logic [DATA_W-1:0] bus
);

  localparam int B_PC  = 1;
  localparam int B_AR  = 2;
  localparam int B_IR  = 3;
  localparam int B_AC  = 4;
  localparam int B_R   = 5;
  localparam int B_R4  = 7;
  localparam int B_R3  = 8;
  localparam int B_R2  = 9;
  localparam int B_R1  = 10;
  localparam int B_DM  = 11;
  localparam int B_ALU = 12;

  localparam logic [DATA_W-1:0] ZERO = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] ONE  = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] pc_q, ar_q, ir_q, ac_q, r_q, r1_q, r2_q, r3_q, r4_q;
  logic [DATA_W-1:0] pc_d, ar_d, ir_d, ac_d, r_d, r1_d, r2_d, r3_d, r4_d;
  logic [DATA_W-1:0] bus_s;
  logic [DATA_W-1:0] alu_s;

  // Per-register update priority below reset: clear, then load from bus, then increment.
  function automatic logic [DATA_W-1:0] next_val(
    input logic [DATA_W-1:0] cur,
    input logic              clr,
    input logic              load,
    input logic              inc,
    input logic [DATA_W-1:0] src
  );
    if (clr)       return ZERO;
    else if (load) return src;
    else if (inc)  return cur + ONE;
    else           return cur;
  endfunction

  // Bus source multiplexer.
  always_comb begin
    bus_s = ZERO;
    case (read_en)
      4'd1:    bus_s = pc_q;
      4'd2:    bus_s = ar_q;
      4'd4:    bus_s = ir_q;
      4'd5:    bus_s = ac_q;
      4'd6:    bus_s = r_q;
      4'd7:    bus_s = r1_q;
      4'd8:    bus_s = r2_q;
      4'd9:    bus_s = r3_q;
      4'd10:   bus_s = r4_q;
      4'd12:   bus_s = dm_rdata;
      4'd13:   bus_s = im_rdata;
      4'd14:   bus_s = ac_q;
      default: bus_s = ZERO;
    endcase
  end

  // ALU on A=AC, B=R; results wrap to DATA_W bits.
  always_comb begin
    alu_s = ac_q;
    case (alu_op)
      3'd1:    alu_s = ac_q + r_q;
      3'd2:    alu_s = ac_q - r_q;
`ifdef DATAPATH_MULT_EN
      3'd3:    alu_s = ac_q * r_q;
`else
      3'd3:    alu_s = ac_q;
`endif
      3'd4:    alu_s = {ac_q[DATA_W-2:0], 1'b0};
      default: alu_s = ac_q;
    endcase
  end

  // Next-state selection; the ALU load path outranks a bus load into AC.
  always_comb begin
    pc_d = next_val(pc_q, clr_en[B_PC], write_en[B_PC], inc_en[B_PC], bus_s);
    ar_d = next_val(ar_q, clr_en[B_AR], write_en[B_AR], inc_en[B_AR], bus_s);
    ir_d = next_val(ir_q, clr_en[B_IR], write_en[B_IR], 1'b0, bus_s);
    r_d  = next_val(r_q,  clr_en[B_R],  write_en[B_R],  1'b0, bus_s);
    r1_d = next_val(r1_q, clr_en[B_R1], write_en[B_R1], 1'b0, bus_s);
    r2_d = next_val(r2_q, clr_en[B_R2], write_en[B_R2], 1'b0, bus_s);
    r3_d = next_val(r3_q, clr_en[B_R3], write_en[B_R3], 1'b0, bus_s);
    r4_d = next_val(r4_q, clr_en[B_R4], write_en[B_R4], 1'b0, bus_s);
    if (write_en[B_ALU] && !clr_en[B_AC]) begin
      ac_d = alu_s;
    end else begin
      ac_d = next_val(ac_q, clr_en[B_AC], write_en[B_AC], inc_en[B_AC], bus_s);
    end
  end

  // Register file state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= ZERO; ar_q <= ZERO; ir_q <= ZERO; ac_q <= ZERO; r_q <= ZERO;
      r1_q <= ZERO; r2_q <= ZERO; r3_q <= ZERO; r4_q <= ZERO;
    end else begin
      pc_q <= pc_d; ar_q <= ar_d; ir_q <= ir_d; ac_q <= ac_d; r_q <= r_d;
      r1_q <= r1_d; r2_q <= r2_d; r3_q <= r3_d; r4_q <= r4_d;
    end
  end

  assign bus         = bus_s;
  assign dm_wdata    = bus_s;
  assign dm_we       = write_en[B_DM];
  assign im_addr     = pc_q;
  assign dm_addr     = ar_q;
  assign instruction = ir_q[OPC_W-1:0];
  assign z           = {15'd0, (ac_q == ZERO)};

  // Enable bits with no destination in this datapath.
  logic unused_bits_s;
  assign unused_bits_s = ^{write_en[0], write_en[6], write_en[15:13],
                           inc_en[0], inc_en[15:5], inc_en[3],
                           clr_en[0], clr_en[6], clr_en[15:11]};

endmodule

// File: tb/tb_datapath_bus.sv
// Bench for datapath_bus: directed scenarios then random control words, checked against a
// register-map reference model indexed by enable-bit number.
module tb_datapath_bus;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  read_en;
  logic [15:0] write_en, inc_en, clr_en;
  logic [2:0]  alu_op;
  logic [15:0] im_rdata, dm_rdata;
  logic [15:0] im_addr, dm_addr, dm_wdata, z, bus;
  logic        dm_we;
  logic [4:0]  instruction;

  int vectors = 0;
  int miscompares = 0;

  // Model state: mreg[k] is the register owning enable bit k (1 PC,2 AR,3 IR,4 AC,5 R,7 R4,8 R3,9 R2,10 R1).
  logic [15:0] mreg [16];
  int reg_bits [9] = '{1, 2, 3, 4, 5, 7, 8, 9, 10};

  datapath_bus #(.DATA_W(16), .OPC_W(5)) dut (
    .clk(clk), .rst(rst), .read_en(read_en), .write_en(write_en), .inc_en(inc_en),
    .clr_en(clr_en), .alu_op(alu_op), .im_rdata(im_rdata), .dm_rdata(dm_rdata),
    .im_addr(im_addr), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we),
    .instruction(instruction), .z(z), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_bus();
    case (read_en)
      4'd1:  return mreg[1];
      4'd2:  return mreg[2];
      4'd4:  return mreg[3];
      4'd5:  return mreg[4];
      4'd6:  return mreg[5];
      4'd7:  return mreg[10];
      4'd8:  return mreg[9];
      4'd9:  return mreg[8];
      4'd10: return mreg[7];
      4'd12: return dm_rdata;
      4'd13: return im_rdata;
      4'd14: return mreg[4];
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] ref_alu();
    int a, b;
    a = int'(mreg[4]);
    b = int'(mreg[5]);
    case (alu_op)
      3'd1: return 16'((a + b) % 65536);
      3'd2: return 16'((a - b + 65536) % 65536);
`ifdef DATAPATH_MULT_EN
      3'd3: return 16'((longint'(a) * longint'(b)) % 64'd65536);
`endif
      3'd4: return 16'((a * 2) % 65536);
      default: return mreg[4];
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] re, input logic [15:0] we, input logic [15:0] inc,
                       input logic [15:0] clr, input logic [2:0] op, input logic [15:0] im,
                       input logic [15:0] dm, input logic r);
    read_en = re; write_en = we; inc_en = inc; clr_en = clr;
    alu_op = op; im_rdata = im; dm_rdata = dm; rst = r;
  endtask

  // Let combinational outputs settle, then compare every output against the model.
  task automatic settle_check();
    #3;
    check("bus",         bus,                ref_bus());
    check("dm_wdata",    dm_wdata,           ref_bus());
    check("dm_we",       {15'd0, dm_we},     {15'd0, write_en[11]});
    check("dm_addr",     dm_addr,            mreg[2]);
    check("im_addr",     im_addr,            mreg[1]);
    check("instruction", {11'd0, instruction}, {11'd0, mreg[3][4:0]});
    check("z",           z,                  {15'd0, (mreg[4] == 16'h0000)});
  endtask

  task automatic clk_edge();
    logic [15:0] nxt [16];
    logic [15:0] b, a;
    @(posedge clk);
    b = ref_bus();
    a = ref_alu();
    nxt = mreg;
    foreach (reg_bits[i]) begin
      int k;
      k = reg_bits[i];
      if (rst)                           nxt[k] = 16'h0000;
      else if (clr_en[k])                nxt[k] = 16'h0000;
      else if (k == 4 && write_en[12])   nxt[k] = a;
      else if (write_en[k])              nxt[k] = b;
      else if (inc_en[k] && (k == 1 || k == 2 || k == 4)) nxt[k] = 16'((int'(mreg[k]) + 1) % 65536);
      else                               nxt[k] = mreg[k];
    end
    mreg = nxt;
    #1;
  endtask

  task automatic step();
    settle_check();
    clk_edge();
  endtask

  initial begin
    foreach (mreg[i]) mreg[i] = 16'h0000;
    drive(4'd0, 16'h0, 16'h0, 16'h0, 3'd0, 16'h0, 16'h0, 1'b1);
    clk_edge();

    // AC=1234 then a one-cycle reset.
    drive(4'd13, 16'h0010, 16'h0, 16'h0, 3'd0, 16'h1234, 16'h0, 1'b0); step();
    drive(4'd5, 16'h0, 16'h0, 16'h0, 3'd0, 16'h0, 16'h0, 1'b1); step();
    drive(4'd0, 16'h0, 16'h0, 16'h0, 3'd0, 16'h0, 16'h0, 1'b0); settle_check();
    check("rst_z", z, 16'h0001);
    check("rst_instr", {11'd0, instruction}, 16'h0000);
    check("rst_bus", bus, 16'h0000);
    clk_edge();

    // Fetch into IR, then increment PC.
    drive(4'd13, 16'h0008, 16'h0, 16'h0, 3'd0, 16'h0013, 16'h0, 1'b0); step();
    drive(4'd0, 16'h0, 16'h0002, 16'h0, 3'd0, 16'h0, 16'h0, 1'b0); step();
    drive(4'd0, 16'h0, 16'h0, 16'h0, 3'd0, 16'h0, 16'h0, 1'b0); settle_check();
    check("fetch_instr", {11'd0, instruction}, 16'h0013);
    check("fetch_pc", im_addr, 16'h0001);

    // AC->AR, then DM->AC.
    drive(4'd13, 16'h0010, 16'h0, 16'h0, 3'd0, 16'h0005, 16'h0, 1'b0); step();
    drive(4'd5, 16'h0004, 16'h0, 16'h0, 3'd0, 16'h0, 16'h0, 1'b0); step();
    drive(4'd12, 16'h0010, 16'h0, 16'h0, 3'd0, 16'h0, 16'h00AA, 1'b0); step();
    drive(4'd5, 16'h0, 16'h0, 16'h0, 3'd0, 16'h0, 16'h0, 1'b0); settle_check();
    check("ld_ar", dm_addr, 16'h0005);
    check("ld_ac", bus, 16'h00AA);

    // ALU ops with R=5.
    drive(4'd13, 16'h0020, 16'h0, 16'h0, 3'd0, 16'h0005, 16'h0, 1'b0); step();
    drive(4'd13, 16'h0010, 16'h0, 16'h0, 3'd0, 16'h0003, 16'h0, 1'b0); step();
    drive(4'd0, 16'h1010, 16'h0, 16'h0, 3'd1, 16'h0, 16'h0, 1'b0); step();
    drive(4'd5, 16'h0, 16'h0, 16'h0, 3'd0, 16'h0, 16'h0, 1'b0); settle_check();
    check("alu_add", bus, 16'h0008);
    drive(4'd13, 16'h0010, 16'h0, 16'h0, 3'd0, 16'h0003, 16'h0, 1'b0); step();
    drive(4'd0, 16'h1000, 16'h0, 16'h0, 3'd2, 16'h0, 16'h0, 1'b0); step();
    drive(4'd5, 16'h0, 16'h0, 16'h0, 3'd0, 16'h0, 16'h0, 1'b0); settle_check();
    check("alu_sub", bus, 16'hFFFE);
    check("alu_sub_z", z, 16'h0000);
    drive(4'd13, 16'h0010, 16'h0, 16'h0, 3'd0, 16'h8001, 16'h0, 1'b0); step();
    drive(4'd0, 16'h1000, 16'h0, 16'h0, 3'd4, 16'h0, 16'h0, 1'b0); step();
    drive(4'd5, 16'h0, 16'h0, 16'h0, 3'd0, 16'h0, 16'h0, 1'b0); settle_check();
    check("alu_shl", bus, 16'h0002);
    drive(4'd13, 16'h0010, 16'h0, 16'h0, 3'd0, 16'h0003, 16'h0, 1'b0); step();
    drive(4'd0, 16'h1000, 16'h0, 16'h0, 3'd3, 16'h0, 16'h0, 1'b0); step();
    drive(4'd5, 16'h0, 16'h0, 16'h0, 3'd0, 16'h0, 16'h0, 1'b0); settle_check();
`ifdef DATAPATH_MULT_EN
    check("alu_mul", bus, 16'h000F);
`else
    check("alu_mul", bus, 16'h0003);
`endif

    // AC wrap to zero; PC clear beats increment.
    drive(4'd13, 16'h0010, 16'h0, 16'h0, 3'd0, 16'hFFFF, 16'h0, 1'b0); step();
    drive(4'd0, 16'h0, 16'h0012, 16'h0002, 3'd0, 16'h0, 16'h0, 1'b0); step();
    drive(4'd0, 16'h0, 16'h0, 16'h0, 3'd0, 16'h0, 16'h0, 1'b0); settle_check();
    check("inc_wrap_z", z, 16'h0001);
    check("clr_pc", im_addr, 16'h0000);

    // Memory write strobe from AC.
    drive(4'd13, 16'h0010, 16'h0, 16'h0, 3'd0, 16'h00C3, 16'h0, 1'b0); step();
    drive(4'd5, 16'h0800, 16'h0, 16'h0, 3'd0, 16'h0, 16'h0, 1'b0); settle_check();
    check("dm_we", {15'd0, dm_we}, 16'h0001);
    check("dm_wdata", dm_wdata, 16'h00C3);
    check("dm_addr", dm_addr, 16'h0005);
    clk_edge();

    // Random control words.
    for (int n = 0; n < 600; n++) begin
      drive(4'($urandom_range(0, 15)),
            16'($urandom & $urandom & $urandom),
            16'($urandom & $urandom & $urandom),
            16'($urandom & $urandom & $urandom & $urandom),
            3'($urandom_range(0, 7)),
            (n % 7 == 0) ? 16'hFFFF : 16'($urandom),
            16'($urandom),
            ($urandom_range(0, 39) == 0));
      step();
    end
    drive(4'd0, 16'h0, 16'h0, 16'h0, 3'd0, 16'h0, 16'h0, 1'b0); settle_check();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
